// File: rtl/pl_pkg.sv
// Shared types and control-field layout for the elastic pipeline stage.
// CTRL_WIDTH of a stage is built as a sum of the named field widths below.
package pl_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pl_state_t;

    localparam int CW_REG_WRITE   = 1;
    localparam int CW_MEM_WRITE   = 1;
    localparam int CW_MEM_READ    = 1;
    localparam int CW_JUMP        = 1;
    localparam int CW_BRANCH      = 1;
    localparam int CW_ALU_SRC     = 1;
    localparam int CW_RESULT_SRC  = 2;
    localparam int CW_ALU_CONTROL = 4;
    localparam int CW_IMM_SRC     = 3;
    localparam int CW_SPARE       = 1;

    localparam int OFS_REG_WRITE   = 0;
    localparam int OFS_MEM_WRITE   = OFS_REG_WRITE   + CW_REG_WRITE;
    localparam int OFS_MEM_READ    = OFS_MEM_WRITE   + CW_MEM_WRITE;
    localparam int OFS_JUMP        = OFS_MEM_READ    + CW_MEM_READ;
    localparam int OFS_BRANCH      = OFS_JUMP        + CW_JUMP;
    localparam int OFS_ALU_SRC     = OFS_BRANCH      + CW_BRANCH;
    localparam int OFS_RESULT_SRC  = OFS_ALU_SRC     + CW_ALU_SRC;
    localparam int OFS_ALU_CONTROL = OFS_RESULT_SRC  + CW_RESULT_SRC;
    localparam int OFS_IMM_SRC     = OFS_ALU_CONTROL + CW_ALU_CONTROL;
    localparam int OFS_SPARE       = OFS_IMM_SRC     + CW_IMM_SRC;

    localparam int CTRL_W_DEFAULT  = OFS_SPARE + CW_SPARE;

    function automatic logic [1:0] occupancy_of(input pl_state_t st);
        case (st)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pl_reg_elastic_slot.sv
// One ctrl+data holding register: load captures both fields, clear zeroes
// only the control field so a squashed entry keeps its payload bits.
module pl_slot #(
    parameter int CW = 16,
    parameter int DW = 170
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clr_ctrl,
    input  logic [CW-1:0] i_ctrl,
    input  logic [DW-1:0] i_data,
    output logic [CW-1:0] o_ctrl,
    output logic [DW-1:0] o_data
);

    logic [CW-1:0] r_ctrl;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (i_clr_ctrl) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end
    end

    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pl_reg_elastic.sv
// Generic elastic pipeline stage: main slot drives the outputs, optional skid
// slot absorbs one extra entry so in_ready can come straight from a flop.
module pl_reg_elastic
    import pl_pkg::*;
#(
    parameter int CTRL_WIDTH = CTRL_W_DEFAULT,
    parameter int DATA_WIDTH = 170,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    pl_state_t             r_state;
    pl_state_t             w_state_next;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_m_load;
    logic                  w_m_from_s;
    logic                  w_s_load;
    logic [CTRL_WIDTH-1:0] w_m_ctrl;
    logic [DATA_WIDTH-1:0] w_m_data;
    logic [CTRL_WIDTH-1:0] w_s_ctrl;
    logic [DATA_WIDTH-1:0] w_s_data;

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_next;
    end

    // Flush wins over every transition and suppresses all loads.
    always_comb begin
        w_state_next = r_state;
        w_m_load     = 1'b0;
        w_m_from_s   = 1'b0;
        w_s_load     = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    w_state_next = ONE;
                    w_m_load     = 1'b1;
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_m_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_next = FULL;
                        w_s_load     = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: if (w_out_fire) begin
                    w_state_next = ONE;
                    w_m_load     = 1'b1;
                    w_m_from_s   = 1'b1;
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    pl_slot #(.CW(CTRL_WIDTH), .DW(DATA_WIDTH)) u_slot_m (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_m_load),
        .i_clr_ctrl (flush),
        .i_ctrl     (w_m_from_s ? w_s_ctrl : in_ctrl),
        .i_data     (w_m_from_s ? w_s_data : in_data),
        .o_ctrl     (w_m_ctrl),
        .o_data     (w_m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            // Ready is registered from the next state, so out_ready never reaches in_ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_in_ready <= 1'b1;
                else     r_in_ready <= (w_state_next != FULL);
            end
            assign w_in_ready = r_in_ready;

            pl_slot #(.CW(CTRL_WIDTH), .DW(DATA_WIDTH)) u_slot_s (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_s_load),
                .i_clr_ctrl (flush),
                .i_ctrl     (in_ctrl),
                .i_data     (in_data),
                .o_ctrl     (w_s_ctrl),
                .o_data     (w_s_data)
            );
        end else begin : g_noskid
            assign w_in_ready = out_ready | ~w_out_valid;
            assign w_s_ctrl   = '0;
            assign w_s_data   = '0;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? w_m_ctrl : '0;
    assign out_data  = w_m_data;
    assign occupancy = occupancy_of(r_state);

endmodule
